// File: rtl/wave_pkg.sv
// ============================================================================
// Module   : wave_pkg
// Brief    : Shared state encoding and default widths for the capture buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wave_pkg;

    localparam int unsigned C_DATA_WIDTH    = 8;
    localparam int unsigned C_ADDRESS_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/capture_ram.sv
// ============================================================================
// Module   : capture_ram
// Brief    : Simple dual-port sample store, synchronous write, 1-cycle read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module capture_ram
    import wave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = C_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = C_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/wave_capture.sv
// ============================================================================
// Module   : wave_capture
// Brief    : Level-triggered capture of DEPTH samples with valid/ready readout.
//            Optional macro WAVE_CAPTURE_AUTO_REARM_EN re-arms after readout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wave_capture
    import wave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = C_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = C_ADDRESS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  triggered
);

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    prev_q, prev_d;
    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic                     issue_done_q, issue_done_d;
    logic                     pend_q, pend_d;
    logic                     pend_last_q, pend_last_d;
    logic                     out_v_q, out_v_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     skid_v_q, skid_v_d;
    logic [DATA_WIDTH-1:0]    skid_data_q, skid_data_d;
    logic                     skid_last_q, skid_last_d;

    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_waddr;
    logic                     ram_re;
    logic [DATA_WIDTH-1:0]    ram_rdata;
    logic                     pop;
    logic [1:0]               held_cnt;

    capture_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (din),
        .re    (ram_re),
        .raddr (raddr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wptr_d       = wptr_q;
        raddr_d      = raddr_q;
        issue_done_d = issue_done_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        out_v_d      = out_v_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_v_d     = skid_v_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        ram_we       = 1'b0;
        ram_waddr    = wptr_q;
        ram_re       = 1'b0;
        pop          = out_v_q && rd_ready;
        held_cnt     = 2'(out_v_q) + 2'(skid_v_q) - 2'(pop);

        case (state_q)
            ST_IDLE: begin
                prev_d = '1;
                wptr_d = '0;
                if (arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (en) begin
                    prev_d = din;
                    if (force_trig || (prev_q < trig_level && din >= trig_level)) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        wptr_d    = ADDRESS_WIDTH'(1);
                        state_d   = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (en) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + ADDRESS_WIDTH'(1);
                    if (wptr_q == '1) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                // Issue a read only if its data is guaranteed a free slot next
                // cycle; the skid slot lets this sustain one sample per cycle.
                ram_re      = !issue_done_q && ((held_cnt + 2'(pend_q)) <= 2'd1);
                pend_d      = ram_re;
                pend_last_d = ram_re && (raddr_q == '1);
                if (ram_re) begin
                    raddr_d = raddr_q + ADDRESS_WIDTH'(1);
                    if (raddr_q == '1) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (pop) begin
                    out_v_d    = skid_v_q;
                    out_data_d = skid_data_q;
                    out_last_d = skid_last_q;
                    skid_v_d   = 1'b0;
                end
                if (pend_q) begin
                    if (!out_v_d) begin
                        out_v_d    = 1'b1;
                        out_data_d = ram_rdata;
                        out_last_d = pend_last_q;
                    end else begin
                        skid_v_d    = 1'b1;
                        skid_data_d = ram_rdata;
                        skid_last_d = pend_last_q;
                    end
                end
                if (pop && out_last_q) begin
`ifdef WAVE_CAPTURE_AUTO_REARM_EN
                    state_d = ST_ARMED;
`else
                    state_d = ST_IDLE;
`endif
                    prev_d       = '1;
                    wptr_d       = '0;
                    raddr_d      = '0;
                    issue_done_d = 1'b0;
                    pend_d       = 1'b0;
                    pend_last_d  = 1'b0;
                    out_v_d      = 1'b0;
                    out_data_d   = '0;
                    out_last_d   = 1'b0;
                    skid_v_d     = 1'b0;
                    skid_data_d  = '0;
                    skid_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= '1;
            wptr_q       <= '0;
            raddr_q      <= '0;
            issue_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_v_q     <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wptr_q       <= wptr_d;
            raddr_q      <= raddr_d;
            issue_done_q <= issue_done_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            out_v_q      <= out_v_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_v_q     <= skid_v_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign rd_valid  = out_v_q;
    assign rd_data   = out_data_q;
    assign rd_last   = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign triggered = (state_q == ST_CAPTURE) || (state_q == ST_READOUT);

endmodule

`default_nettype wire

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Triggered capture buffer directly downstream of the sine/cosine generator; consumes one sample stream (e.g. doutsin) qualified by the generator's en strobe.
- When armed, detects a rising crossing of a programmable level, stores DEPTH consecutive samples in an internal RAM, then streams them out over a valid/ready port for display or host readout.
- Forms the "scope" stage of the signal-generator pipeline.

Parameters:
- DATA_WIDTH, 8, sample width; matches generator output width.
- ADDRESS_WIDTH, 8, capture RAM address width; DEPTH = 2**ADDRESS_WIDTH samples.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  sample strobe; din is valid in cycles where en=1.
- din  input  DATA_WIDTH  sample from generator, unsigned.
- arm  input  1  single-cycle request to start waiting for a trigger.
- force_trig  input  1  immediate trigger while ARMED, regardless of level.
- trig_level  input  DATA_WIDTH  unsigned trigger threshold; sampled every qualified sample.
- rd_ready  input  1  downstream accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds a captured sample.
- rd_data  output  DATA_WIDTH  captured sample, oldest first.
- rd_last  output  1  high with final (DEPTH-th) sample.
- busy  output  1  high in ARMED, CAPTURE, READOUT.
- triggered  output  1  high from trigger until return to IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; rd_valid=0, rd_data=0, rd_last=0, busy=0, triggered=0; write/read pointers=0; prev-sample register=all-ones (prevents false trigger on first sample).
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE: arm=1 -> ARMED next cycle. Other inputs ignored.
- ARMED: on each en=1 cycle, prev <- din. Trigger when en=1 and (force_trig=1 or (prev < trig_level and din >= trig_level)). Trigger sample is written to address 0, write pointer=1, go to CAPTURE, triggered=1. force_trig without en=1 waits for next en. arm while ARMED: ignored.
- CAPTURE: each en=1 writes din at write pointer, pointer+1. Write of address DEPTH-1 -> READOUT next cycle. en=0 cycles stall capture (no write). arm, force_trig ignored.
- READOUT: RAM has 1-cycle synchronous read; first rd_valid asserts no later than 2 cycles after entering READOUT. Standard valid/ready: rd_data/rd_last stable while rd_valid=1 and rd_ready=0; transfer on rd_valid&&rd_ready. Sustained rd_ready=1 gives one sample per cycle after first (read-ahead/skid required). Samples emitted in address order 0..DEPTH-1; rd_last=1 only with address DEPTH-1. Transfer of last sample -> IDLE next cycle, rd_valid=0, triggered=0, busy=0. en/din ignored during READOUT (samples dropped).
- Pointer widths ADDRESS_WIDTH; wrap never occurs in normal operation (transitions happen at DEPTH-1).
- Comparison strictly unsigned, DATA_WIDTH bits; trig_level=0 can trigger only via force_trig (prev<0 impossible).
- Reset mid-operation: immediate return to reset values; RAM contents undefined, never emitted before a new capture.

Optional Feature:
- Macro WAVE_CAPTURE_AUTO_REARM_EN.
- Defined: after last readout transfer, go to ARMED instead of IDLE (busy stays 1, triggered clears, prev reset to all-ones); arm input still accepted in IDLE after reset.
- Undefined: return to IDLE; new arm pulse required per capture.

Decomposition:
- Shared package wave_pkg: state enum typedef (IDLE/ARMED/CAPTURE/READOUT), default DATA_WIDTH/ADDRESS_WIDTH constants.
- One sub-module: capture_ram (simple dual-port, sync write, 1-cycle sync read, DEPTH x DATA_WIDTH, no reset on array).

Test Plan:
- Reset: hold rst=0 with arm=1, en=1 -> all outputs 0, state stays IDLE; release, no rd_valid ever without arm.
- Ramp trigger: ADDRESS_WIDTH=4, trig_level=100, din ramps 0,10,...,250 with en=1 after arm -> first read sample 100, 16 samples 100..250 in order, rd_last on 16th.
- No crossing: arm, din constant 200, trig_level=100 -> stays ARMED, triggered=0 for 1000 cycles; force_trig+en with din=7 -> first sample 7.
- Backpressure: rd_ready toggles random 30% -> rd_data stable while stalled, no drops/duplicates; rd_ready=1 constant -> 16 transfers in 16 consecutive cycles after first.
- Sparse en: en every 4th cycle during CAPTURE -> only qualified samples stored; readout matches en-qualified sequence.
- Async reset in CAPTURE after 5 samples -> outputs zero immediately; re-arm captures a fresh, correct buffer; with WAVE_CAPTURE_AUTO_REARM_EN, second trigger captured without arm pulse.
